operand_entry_unit: RTL and testbench

OPERAND_ENTRY_UNIT -- requirements
Module: operand_entry_unit

---
 rtl/operand_entry_unit.sv | 172 +++++++++++++++++
 tb/tb_operand_entry_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry_unit.sv
`default_nettype none
// ============================================================================
// Module      : operand_entry_unit
// Description : Keypad operand entry. Collects BCD digits and a sign into a
//               display buffer, converts the buffer to a binary magnitude
//               one digit per cycle, range-checks it and presents a signed
//               two's-complement result through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_entry_unit #(
    parameter int DIGITS  = 3,
    parameter int WIDTH   = 8,
    parameter int MAX_MAG = 127
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            key_value,
    input  logic                  key_trig,
    input  logic                  out_ready,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  neg,
    output logic                  busy,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      result,
    output logic                  range_err
);

    localparam int c_bcd_w = DIGITS * 4;
    // Accumulator must hold 10^DIGITS-1 regardless of WIDTH.
    localparam int c_acc_w = $clog2(10 ** DIGITS);
    localparam int c_cnt_w = $clog2(DIGITS + 1);
    localparam logic [c_cnt_w-1:0] c_digits = c_cnt_w'(DIGITS);

    localparam logic [3:0] c_key_sign  = 4'hA;
    localparam logic [3:0] c_key_bksp  = 4'hB;
    localparam logic [3:0] c_key_clear = 4'hC;
    localparam logic [3:0] c_key_enter = 4'hE;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_CONVERT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_bcd_w-1:0]   r_bcd;
    logic [c_bcd_w-1:0]   r_shift;
    logic                 r_neg;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_cnt_w-1:0]   r_idx;
    logic [c_acc_w-1:0]   r_acc;
    logic [WIDTH-1:0]     r_result;
    logic                 r_range_err;

    logic                 w_key_digit;
    logic                 w_key_sign;
    logic                 w_key_bksp;
    logic                 w_key_clear;
    logic                 w_key_enter;
    logic [3:0]           w_digit;
    logic [c_acc_w+3:0]   w_acc_x10;
    logic [c_acc_w-1:0]   w_acc_next;
    logic [31:0]          w_acc32;
    logic [31:0]          w_limit;
    logic                 w_range_err;
    logic [WIDTH-1:0]     w_mag_w;
    logic [WIDTH-1:0]     w_signed_w;

    assign w_key_digit = key_trig && (key_value <= 4'd9);
    assign w_key_sign  = key_trig && (key_value == c_key_sign);
    assign w_key_bksp  = key_trig && (key_value == c_key_bksp);
    assign w_key_clear = key_trig && (key_value == c_key_clear);
    assign w_key_enter = key_trig && (key_value == c_key_enter);

    // Most significant captured digit feeds the multiply-accumulate.
    assign w_digit    = r_shift[c_bcd_w-1 -: 4];
    assign w_acc_x10  = ({4'b0000, r_acc} << 3) + ({4'b0000, r_acc} << 1);
    assign w_acc_next = w_acc_x10[c_acc_w-1:0] + {{(c_acc_w-4){1'b0}}, w_digit};

    // Negative operands may reach one further than positive ones.
    assign w_acc32     = 32'(r_acc);
    assign w_limit     = r_neg ? (32'(MAX_MAG) + 32'd1) : 32'(MAX_MAG);
    assign w_range_err = (w_acc32 > w_limit);

    generate
        if (c_acc_w >= WIDTH) begin : g_mag_trunc
            assign w_mag_w = r_acc[WIDTH-1:0];
        end else begin : g_mag_ext
            assign w_mag_w = {{(WIDTH-c_acc_w){1'b0}}, r_acc};
        end
    endgenerate

    // Two's complement negate; a zero magnitude stays zero.
    assign w_signed_w = r_neg ? (~w_mag_w + 1'b1) : w_mag_w;

    assign bcd       = r_bcd;
    assign neg       = r_neg;
    assign busy      = (r_state == ST_CONVERT) || (r_state == ST_CHECK);
    assign out_valid = (r_state == ST_HOLD);
    assign result    = r_result;
    assign range_err = r_range_err;

    // Entry buffer, conversion datapath and control state machine.
    always_ff @(posedge clock) begin
        if (reset || w_key_clear) begin
            r_state     <= ST_ENTRY;
            r_bcd       <= '0;
            r_shift     <= '0;
            r_neg       <= 1'b0;
            r_count     <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_range_err <= 1'b0;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (w_key_digit) begin
                        if (r_count < c_digits) begin
                            r_bcd   <= (r_bcd << 4) | c_bcd_w'(key_value);
                            r_count <= r_count + 1'b1;
                        end
                    end else if (w_key_bksp) begin
                        if (r_count != '0) begin
                            r_bcd   <= r_bcd >> 4;
                            r_count <= r_count - 1'b1;
                        end
                    end else if (w_key_sign) begin
                        r_neg <= ~r_neg;
                    end else if (w_key_enter) begin
                        r_shift <= r_bcd;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    // Step 0 is a lead-in slot; steps 1..DIGITS consume
                    // one digit each, most significant first.
                    if (r_idx != '0) begin
                        r_acc   <= w_acc_next;
                        r_shift <= r_shift << 4;
                    end
                    if (r_idx == c_digits) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_CHECK: begin
                    r_range_err <= w_range_err;
                    r_result    <= w_range_err ? '0 : w_signed_w;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_bcd   <= '0;
                        r_neg   <= 1'b0;
                        r_count <= '0;
                        r_state <= ST_ENTRY;
                    end
                end
                default: begin
                    r_state <= ST_ENTRY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_entry_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_entry_unit
// Description : Self-checking bench for operand_entry_unit. Key presses are
//               mirrored in a digit-list model; each enter pushes the
//               expected result onto a scoreboard popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_entry_unit;

    localparam int DIGITS  = 3;
    localparam int WIDTH   = 8;
    localparam int MAX_MAG = 127;

    logic                clock = 1'b0;
    logic                reset;
    logic [3:0]          key_value;
    logic                key_trig;
    logic                out_ready;
    logic [DIGITS*4-1:0] bcd;
    logic                neg;
    logic                busy;
    logic                out_valid;
    logic [WIDTH-1:0]    result;
    logic                range_err;

    operand_entry_unit #(
        .DIGITS  (DIGITS),
        .WIDTH   (WIDTH),
        .MAX_MAG (MAX_MAG)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key_value (key_value),
        .key_trig  (key_trig),
        .out_ready (out_ready),
        .bcd       (bcd),
        .neg       (neg),
        .busy      (busy),
        .out_valid (out_valid),
        .result    (result),
        .range_err (range_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int res;
        bit err;
        int ecyc;
    } exp_t;

    exp_t sbq[$];
    int   digs[$];
    bit   mneg = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   prev_valid = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int model_bcd();
        int v = 0;
        foreach (digs[i]) v = v * 16 + digs[i];
        return v;
    endfunction

    function automatic exp_t model_result(input int ecyc);
        exp_t e;
        int   mag = 0;
        foreach (digs[i]) mag = mag * 10 + digs[i];
        e.err  = mneg ? (mag > MAX_MAG + 1) : (mag > MAX_MAG);
        e.res  = e.err ? 0 : ((mneg ? -mag : mag) & ((1 << WIDTH) - 1));
        e.ecyc = ecyc;
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        digs.delete();
        mneg = 1'b0;
    endtask

    // Present one key for one cycle; when live, the model follows it.
    task automatic press(input int k, input bit live);
        key_value = k[3:0];
        key_trig  = 1'b1;
        tick();
        key_trig  = 1'b0;
        if (k == 12) begin
            model_clear();
        end else if (live) begin
            if (k <= 9) begin
                if (digs.size() < DIGITS) digs.push_back(k);
            end else if (k == 10) begin
                mneg = ~mneg;
            end else if (k == 11) begin
                if (digs.size() > 0) void'(digs.pop_back());
            end else if (k == 14) begin
                sbq.push_back(model_result(cyc));
            end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            chk("valid_timeout", 0, 1);
            press(12, 0);
            sbq.delete();
        end
    endtask

    task automatic hold_check(input int n);
        for (int i = 0; i < n; i++) begin
            chk("hold_valid", out_valid, 1);
            if (sbq.size() > 0) chk("hold_result", result, sbq[0].res);
            tick();
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        model_clear();
        chk("after_accept_valid", out_valid, 0);
        chk("after_accept_bcd", bcd, 0);
        chk("after_accept_neg", neg, 0);
    endtask

    task automatic run_operand(input int n);
        bit ok;
        press(14, 1);
        wait_valid(ok);
        if (ok) begin
            hold_check(n);
            release_result();
        end
    endtask

    // Monitor: latency on valid rise, scoreboard pop on each handshake.
    always @(negedge clock) begin
        if (out_valid && !prev_valid) begin
            if (sbq.size() == 0) chk("unexpected_valid", 1, 0);
            else chk("latency", cyc - sbq[0].ecyc, DIGITS + 2);
        end
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", result, e.res);
                chk("range_err", range_err, e.err);
            end
        end
        prev_valid = out_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset     = 1'b1;
        key_value = 4'h0;
        key_trig  = 1'b0;
        out_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_bcd", bcd, 0);
        chk("rst_neg", neg, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_err", range_err, 0);
        reset = 1'b0;
        tick();

        // 1,2,7,E -> 127, held 10 cycles before acceptance
        press(1, 1); press(2, 1); press(7, 1);
        chk("bcd_127", bcd, 12'h127);
        press(14, 1);
        chk("busy_after_enter", busy, 1);
        wait_valid(ok);
        if (ok) begin
            hold_check(10);
            release_result();
        end

        // -128 accepted, +128 rejected
        press(10, 1); press(1, 1); press(2, 1); press(8, 1);
        chk("neg_set", neg, 1);
        run_operand(1);
        press(1, 1); press(2, 1); press(8, 1);
        run_operand(0);

        // Digit overflow and backspace underflow
        press(4, 1); press(5, 1); press(6, 1); press(7, 1);
        chk("bcd_456", bcd, 12'h456);
        press(11, 1);
        chk("bcd_045", bcd, 12'h045);
        press(11, 1); press(11, 1); press(11, 1);
        chk("bcd_empty", bcd, 0);
        press(12, 1);

        // Clear during CONVERT
        press(1, 1); press(2, 1); press(14, 1);
        tick();
        chk("busy_convert", busy, 1);
        press(12, 1);
        void'(sbq.pop_back());
        chk("clr_bcd", bcd, 0);
        chk("clr_busy", busy, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_result", result, 0);
        press(3, 1);
        run_operand(0);

        // Reset during CONVERT
        press(9, 1); press(14, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sbq.pop_back());
        model_clear();
        chk("rstc_bcd", bcd, 0);
        chk("rstc_busy", busy, 0);
        chk("rstc_valid", out_valid, 0);
        press(3, 1);
        run_operand(0);

        // Empty entry, negative zero, key ignored while busy
        run_operand(0);
        press(10, 1); press(0, 1);
        run_operand(0);
        press(5, 1);
        press(14, 1);
        press(9, 0);
        chk("busy_key_ignored", bcd, 12'h005);
        wait_valid(ok);
        if (ok) begin
            press(7, 0);
            chk("hold_key_ignored", bcd, 12'h005);
            release_result();
        end

        // Clear and out_ready together in HOLD
        press(4, 1); press(2, 1); press(14, 1);
        wait_valid(ok);
        if (ok) begin
            out_ready = 1'b1;
            press(12, 0);
            out_ready = 1'b0;
            model_clear();
            chk("clrrdy_valid", out_valid, 0);
            chk("clrrdy_result", result, 0);
            chk("clrrdy_err", range_err, 0);
        end

        // Randomized entry sequences
        for (int it = 0; it < 30; it++) begin
            int n;
            n = $urandom_range(0, 7);
            for (int j = 0; j < n; j++) press($urandom_range(0, 11), 1);
            chk("rand_bcd", bcd, model_bcd());
            chk("rand_neg", neg, mneg);
            run_operand($urandom_range(0, 3));
        end

        tick(); tick();
        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
